ps2_cmd_decoder: RTL and testbench

Receives PS/2 keyboard frames and turns make/break scan codes into the level-coded `win_ctrl_cmd` bus that drives `cursor_ctrl`. It is the producer end of the window/cursor control interface. It sits between the board's PS/2 pins and `cursor_ctrl`, whose own edge detector consumes these levels. It also exposes the raw received byte and a frame-error strobe for debug LEDs.

---
 rtl/ps2_cmd_decoder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ps2_cmd_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder: PS/2 keyboard receiver turning make/break scan codes into
// the level-coded window/cursor command bus consumed by cursor_ctrl.
// Optional feature macro: PS2_PARITY_CHECK_EN (reject frames with even parity).

`ifndef WIN_CTRL_CMD
`define WIN_CTRL_CMD [7:0]
`endif
`ifndef M_UP
`define M_UP 0
`endif
`ifndef M_DOWN
`define M_DOWN 1
`endif
`ifndef M_LEFT
`define M_LEFT 2
`endif
`ifndef M_RIGHT
`define M_RIGHT 3
`endif
`ifndef Z_IN
`define Z_IN 4
`endif
`ifndef Z_OUT
`define Z_OUT 5
`endif
`ifndef M_MODE
`define M_MODE 6
`endif

module ps2_cmd_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic `WIN_CTRL_CMD       win_ctrl_cmd,
    output logic [7:0]               code,
    output logic                     code_valid,
    output logic                     frame_err
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    localparam logic [7:0] C_E0  = 8'hE0;
    localparam logic [7:0] C_F0  = 8'hF0;
    localparam logic [7:0] C_TAB = 8'h0D;

    logic [1:0]       r_clk_sync;
    logic [1:0]       r_dat_sync;
    logic [FLT_W-1:0] r_flt_cnt;
    logic             r_flt;
    logic             r_flt_d;
    logic             w_clk_s;
    logic             w_dat_s;
    logic             w_bit_stb;

    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_code;
    logic             r_code_valid;
    logic             r_frame_err;
`ifdef PS2_PARITY_CHECK_EN
    logic             r_par_ok;
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic `WIN_CTRL_CMD r_cmd;
    logic `WIN_CTRL_CMD w_cmd_next;
    logic             r_tab_held;
    logic             w_tab_next;
    logic             w_is_make;
    logic             w_is_brk;
    logic             w_ext;

    assign w_clk_s   = r_clk_sync[1];
    assign w_dat_s   = r_dat_sync[1];
    assign w_bit_stb = r_flt_d & ~r_flt;

    // Two-stage synchronizers for the raw PS/2 lines (idle bus is high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    // Saturating glitch filter: flip only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flt_cnt <= '0;
            r_flt     <= 1'b1;
            r_flt_d   <= 1'b1;
        end else begin
            r_flt_d <= r_flt;
            if (w_clk_s == r_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                r_flt     <= w_clk_s;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    // Frame receiver with mid-frame timeout; strobes are single-cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par_ok     <= 1'b0;
`endif
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_bit_stb) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    if (w_dat_s) begin
                        r_frame_err <= 1'b1;
                    end else begin
                        r_bit_cnt <= 4'd1;
                    end
                end else if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (!w_dat_s) begin
                        r_frame_err <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!r_par_ok) begin
                        r_frame_err <= 1'b1;
`endif
                    end else begin
                        r_code       <= r_shift;
                        r_code_valid <= 1'b1;
                    end
                end else if (r_bit_cnt == 4'd9) begin
                    // parity bit: data bits are already complete in r_shift
`ifdef PS2_PARITY_CHECK_EN
                    r_par_ok <= ^{r_shift, w_dat_s};
`endif
                    r_bit_cnt <= 4'd10;
                end else begin
                    r_shift   <= {w_dat_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt   <= 4'd0;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Scan-code FSM state and command/tab registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_tab_held <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cmd      <= w_cmd_next;
            r_tab_held <= w_tab_next;
        end
    end

    // Prefix tracking and make/break mapping onto the command bits
    always_comb begin
        w_state_next = r_state;
        w_cmd_next   = r_cmd;
        w_tab_next   = r_tab_held;
        w_is_make    = 1'b0;
        w_is_brk     = 1'b0;
        w_ext        = 1'b0;
        if (r_code_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (r_code == C_E0) begin
                        w_state_next = S_EXT;
                    end else if (r_code == C_F0) begin
                        w_state_next = S_BRK;
                    end else begin
                        w_is_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (r_code == C_F0) begin
                        w_state_next = S_EXT_BRK;
                    end else if (r_code == C_E0) begin
                        w_state_next = S_EXT;
                    end else begin
                        w_is_make    = 1'b1;
                        w_ext        = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_is_brk     = 1'b1;
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_is_brk     = 1'b1;
                    w_ext        = 1'b1;
                    w_state_next = S_IDLE;
                end
            endcase
        end
        if (w_is_make || w_is_brk) begin
            case (r_code)
                8'h75: w_cmd_next[`M_UP]    = w_is_make;
                8'h72: w_cmd_next[`M_DOWN]  = w_is_make;
                8'h6B: w_cmd_next[`M_LEFT]  = w_is_make;
                8'h74: w_cmd_next[`M_RIGHT] = w_is_make;
                8'h55: w_cmd_next[`Z_IN]    = w_is_make;
                8'h4E: w_cmd_next[`Z_OUT]   = w_is_make;
                C_TAB: begin
                    if (!w_ext) begin
                        if (w_is_make) begin
                            if (!r_tab_held) begin
                                w_cmd_next[`M_MODE] = ~r_cmd[`M_MODE];
                            end
                            w_tab_next = 1'b1;
                        end else begin
                            w_tab_next = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign win_ctrl_cmd = r_cmd;
    assign code         = r_code;
    assign code_valid   = r_code_valid;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Randomized self-checking bench for ps2_cmd_decoder against a key-state model.

`ifndef WIN_CTRL_CMD
`define WIN_CTRL_CMD [7:0]
`endif
`ifndef M_UP
`define M_UP 0
`endif
`ifndef M_DOWN
`define M_DOWN 1
`endif
`ifndef M_LEFT
`define M_LEFT 2
`endif
`ifndef M_RIGHT
`define M_RIGHT 3
`endif
`ifndef Z_IN
`define Z_IN 4
`endif
`ifndef Z_OUT
`define Z_OUT 5
`endif
`ifndef M_MODE
`define M_MODE 6
`endif

module tb_ps2_cmd_decoder;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TO_CYC     = 1500;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               ps2_clk;
    logic               ps2_data;
    logic `WIN_CTRL_CMD win_ctrl_cmd;
    logic [7:0]         code;
    logic               code_valid;
    logic               frame_err;

    ps2_cmd_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .win_ctrl_cmd (win_ctrl_cmd),
        .code         (code),
        .code_valid   (code_valid),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: set of held keys plus pending prefix flags
    logic [7:0] m_cmd;
    bit         m_e0, m_f0, m_tab;

    task automatic m_reset();
        m_cmd = '0; m_e0 = 0; m_f0 = 0; m_tab = 0;
    endtask

    function automatic int key_idx(input logic [7:0] b);
        case (b)
            8'h75: return `M_UP;
            8'h72: return `M_DOWN;
            8'h6B: return `M_LEFT;
            8'h74: return `M_RIGHT;
            8'h55: return `Z_IN;
            8'h4E: return `Z_OUT;
            default: return -1;
        endcase
    endfunction

    task automatic m_apply(input logic [7:0] b);
        bit brk, ext;
        int k;
        if (m_f0) begin
            brk = 1; ext = m_e0; m_f0 = 0; m_e0 = 0;
        end else if (b == 8'hE0) begin
            m_e0 = 1; return;
        end else if (b == 8'hF0) begin
            m_f0 = 1; return;
        end else begin
            brk = 0; ext = m_e0; m_e0 = 0;
        end
        k = key_idx(b);
        if (k >= 0) m_cmd[k] = !brk;
        if (b == 8'h0D && !ext) begin
            if (!brk) begin
                if (!m_tab) m_cmd[`M_MODE] = ~m_cmd[`M_MODE];
                m_tab = 1;
            end else begin
                m_tab = 0;
            end
        end
    endtask

    // output monitor: counts strobes and captures the bus around code_valid
    int         cv_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] cmd_at_cv, cmd_after_cv;
    bit         cv_d1 = 0, fe_d1 = 0;

    always @(negedge clk) begin
        if (cv_d1) cmd_after_cv = win_ctrl_cmd;
        if (code_valid) begin
            cv_cnt++;
            cmd_at_cv = win_ctrl_cmd;
            check_eq("cv_width", 32'(cv_d1), 32'd0);
        end
        if (frame_err) begin
            err_cnt++;
            check_eq("fe_width", 32'(fe_d1), 32'd0);
        end
        if (code_valid || frame_err)
            check_eq("strobe_excl", 32'(code_valid & frame_err), 32'd0);
        cv_d1 = code_valid;
        fe_d1 = frame_err;
    end

    int half = 16;

    // drive the first n bits of an 11-bit frame, device style
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic p;
        p = par_ok ? ~(^b) : (^b);
        return {stop_ok ? 1'b1 : 1'b0, p, b, 1'b0};
    endfunction

    // kind: 0 clean, 1 wrong parity, 2 bad stop bit
    task automatic frame_chk(input logic [7:0] b, input int kind);
        int cv0, e0;
        logic [7:0] old;
        bit accept;
        cv0 = cv_cnt; e0 = err_cnt; old = m_cmd;
        cmd_at_cv = 'x; cmd_after_cv = 'x;
        send_bits(mk_frame(b, kind != 1, kind != 2), 11);
        repeat (30) @(negedge clk);
        accept = (kind == 0) || (kind == 1 && !PAR_EN);
        if (accept) m_apply(b);
        check_eq("cv_count", 32'(cv_cnt - cv0), 32'(accept));
        check_eq("fe_count", 32'(err_cnt - e0), 32'(!accept));
        if (accept) begin
            check_eq("code", 32'(code), 32'(b));
            check_eq("cmd_at_cv", 32'(cmd_at_cv), 32'(old));
            check_eq("cmd_after_cv", 32'(cmd_after_cv), 32'(m_cmd));
        end
        check_eq("cmd", 32'(win_ctrl_cmd), 32'(m_cmd));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cmp %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int cv0, e0, r;
        logic [7:0] b;
        logic [7:0] pool [12];
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h55, 8'h4E, 8'h0D, 8'h0D, 8'h1C, 8'h00};

        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        m_reset();
        repeat (5) @(negedge clk);
        check_eq("rst_cmd", 32'(win_ctrl_cmd), 32'd0);
        check_eq("rst_code", 32'(code), 32'd0);
        check_eq("rst_cv", 32'(code_valid), 32'd0);
        check_eq("rst_fe", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // up arrow make then release
        frame_chk(8'hE0, 0);
        frame_chk(8'h75, 0);
        check_eq("up_set", 32'(win_ctrl_cmd[`M_UP]), 32'd1);
        frame_chk(8'hE0, 0);
        frame_chk(8'hF0, 0);
        frame_chk(8'h75, 0);
        check_eq("up_clr", 32'(win_ctrl_cmd[`M_UP]), 32'd0);

        // tab toggle with typematic repeats
        frame_chk(8'h0D, 0);
        check_eq("mode_on", 32'(win_ctrl_cmd[`M_MODE]), 32'd1);
        frame_chk(8'h0D, 0);
        frame_chk(8'h0D, 0);
        check_eq("mode_rep", 32'(win_ctrl_cmd[`M_MODE]), 32'd1);
        frame_chk(8'hF0, 0);
        frame_chk(8'h0D, 0);
        frame_chk(8'h0D, 0);
        check_eq("mode_off", 32'(win_ctrl_cmd[`M_MODE]), 32'd0);

        // simultaneous keys
        frame_chk(8'h55, 0);
        frame_chk(8'h6B, 0);
        check_eq("zin_left", 32'({win_ctrl_cmd[`Z_IN], win_ctrl_cmd[`M_LEFT]}), 32'd3);
        frame_chk(8'hF0, 0);
        frame_chk(8'h55, 0);
        check_eq("zin_drop", 32'({win_ctrl_cmd[`Z_IN], win_ctrl_cmd[`M_LEFT]}), 32'd1);

        // wrong parity and bad stop
        frame_chk(8'h75, 1);
        frame_chk(8'h72, 2);

        // bad start bit: a single strobe with data high
        e0 = err_cnt;
        send_bits(11'h7FF, 1);
        repeat (30) @(negedge clk);
        check_eq("start_err", 32'(err_cnt - e0), 32'd1);

        // timeout after 5 bits
        e0 = err_cnt; cv0 = cv_cnt;
        send_bits(mk_frame(8'h72, 1, 1), 5);
        repeat (TO_CYC + 200) @(negedge clk);
        check_eq("to_err", 32'(err_cnt - e0), 32'd1);
        check_eq("to_cv", 32'(cv_cnt - cv0), 32'd0);
        frame_chk(8'h72, 0);
        check_eq("down_set", 32'(win_ctrl_cmd[`M_DOWN]), 32'd1);

        // glitch one sample shorter than the filter
        e0 = err_cnt; cv0 = cv_cnt;
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_fe", 32'(err_cnt - e0), 32'd0);
        check_eq("glitch_cv", 32'(cv_cnt - cv0), 32'd0);

        // reset with a pending E0 and a partial frame
        frame_chk(8'hE0, 0);
        e0 = err_cnt; cv0 = cv_cnt;
        send_bits(mk_frame(8'h74, 1, 1), 4);
        rst = 1'b0;
        m_reset();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rstmid_cmd", 32'(win_ctrl_cmd), 32'd0);
        check_eq("rstmid_strobe", 32'((err_cnt - e0) + (cv_cnt - cv0)), 32'd0);
        frame_chk(8'h75, 0);
        check_eq("rstmid_up", 32'(win_ctrl_cmd), 32'd1 << `M_UP);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            half = $urandom_range(12, 20);
            pool[11] = 8'($urandom);
            b = pool[$urandom_range(0, 11)];
            r = $urandom_range(0, 19);
            frame_chk(b, (r < 2) ? 1 : ((r == 2) ? 2 : 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
